// File: rtl/seg_scan_decoder.sv
// Receive-side monitor for a multiplexed active-low 7-segment bus. Each anode
// slot is debounced and decoded back to BCD, and the four digits are published together as one frame.

module seg_scan_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_i,
  input  logic [3:0] dig_i,
  input  logic       dp_i,
  output logic [3:0] dig_d_o,
  output logic       dp_d_o
);
  logic [3:0] dig_q;
  logic       dp_q;

  // The next-state value is exported so a frame can close in the same cycle as its last slot write.
  always_comb begin
    dig_d_o = wr_i ? dig_i : dig_q;
    dp_d_o  = wr_i ? dp_i  : dp_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_q <= 4'hF;
      dp_q  <= 1'b0;
    end else begin
      dig_q <= dig_d_o;
      dp_q  <= dp_d_o;
    end
  end
endmodule

module seg_scan_decoder #(
  parameter int STABLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int CNT_W       = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] an,
  input  logic [7:0] sgm,
  output logic [3:0] dig3,
  output logic [3:0] dig2,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic [3:0] dp,
  output logic       frame_done,
  output logic       err_code,
  output logic       err_anode,
  output logic       stale
);
  localparam int NUM_LANES = 4;
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] STAB_SAT  = CNT_W'(STABLE_CYC);
  localparam logic [CNT_W-1:0] TMO_MAX   = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Returns {bad, digit}; unknown patterns decode to blank and flag bad.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40:   r = 5'h00;
      7'h79:   r = 5'h01;
      7'h24:   r = 5'h02;
      7'h30:   r = 5'h03;
      7'h19:   r = 5'h04;
      7'h12:   r = 5'h05;
      7'h02:   r = 5'h06;
      7'h78:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h10:   r = 5'h09;
      7'h7F:   r = 5'h0F;
      default: r = 5'h1F;
    endcase
    return r;
  endfunction

  logic [11:0]                sync1_q, sync2_q, pat_q;
  logic [CNT_W-1:0]           stab_q, stab_d, tmo_q, tmo_d;
  logic [NUM_LANES-1:0]       pend_q, pend_or, pend_d, slot_wr, shd_dp_d, dp_q;
  logic [NUM_LANES-1:0][3:0]  shd_dig_d, dig_q;
  logic [3:0]                 an_s;
  logic [7:0]                 sgm_s;
  logic [4:0]                 dec;
  logic                       accept, onehot, frame_fire;
  logic                       stale_q, stale_d, frame_q;
  logic                       err_code_q, err_code_d, err_anode_q, err_anode_d;

  assign an_s  = sync2_q[11:8];
  assign sgm_s = sync2_q[7:0];
  assign dec   = seg_decode(sgm_s[6:0]);

  always_comb begin
    stab_d = stab_q;
    if (sync2_q != pat_q)        stab_d = '0;
    else if (stab_q != STAB_SAT) stab_d = stab_q + CNT_ONE;

    // Saturating past STAB_LAST makes each settled pattern accept exactly once.
    accept  = (sync2_q == pat_q) && (stab_q == STAB_LAST) && (an_s != 4'hF);
    onehot  = $onehot(~an_s);
    slot_wr = (accept && onehot) ? ~an_s : '0;

    pend_or    = pend_q | slot_wr;
    frame_fire = (|slot_wr) && (pend_or == '1);
    pend_d     = frame_fire ? '0 : pend_or;

    err_code_d  = err_code_q  | ((|slot_wr) & dec[4]);
    err_anode_d = err_anode_q | (accept & ~onehot);

    tmo_d   = tmo_q;
    stale_d = stale_q;
    if (accept) begin
      tmo_d   = '0;
      stale_d = 1'b0;
    end else if (tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + CNT_ONE;
      if (tmo_d == TMO_MAX) stale_d = 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_slot
    seg_scan_slot u_slot (
      .clk     (clk),
      .rst     (rst),
      .wr_i    (slot_wr[i]),
      .dig_i   (dec[3:0]),
      .dp_i    (~sgm_s[7]),
      .dig_d_o (shd_dig_d[i]),
      .dp_d_o  (shd_dp_d[i])
    );
  end

  // Idle bus (all high) is the reset image so nothing is accepted out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      pat_q       <= '1;
      stab_q      <= '0;
      tmo_q       <= '0;
      stale_q     <= 1'b0;
      pend_q      <= '0;
      dig_q       <= {NUM_LANES{4'hF}};
      dp_q        <= '0;
      frame_q     <= 1'b0;
      err_code_q  <= 1'b0;
      err_anode_q <= 1'b0;
    end else begin
      sync1_q     <= {an, sgm};
      sync2_q     <= sync1_q;
      pat_q       <= sync2_q;
      stab_q      <= stab_d;
      tmo_q       <= tmo_d;
      stale_q     <= stale_d;
      pend_q      <= pend_d;
      frame_q     <= frame_fire;
      err_code_q  <= err_code_d;
      err_anode_q <= err_anode_d;
      if (frame_fire) begin
        dig_q <= shd_dig_d;
        dp_q  <= shd_dp_d;
      end
    end
  end

  assign dig0       = dig_q[0];
  assign dig1       = dig_q[1];
  assign dig2       = dig_q[2];
  assign dig3       = dig_q[3];
  assign dp         = dp_q;
  assign frame_done = frame_q;
  assign err_code   = err_code_q;
  assign err_anode  = err_anode_q;
  assign stale      = stale_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: table-driven scans, directed corner sequences and
// random bus holds checked against a per-hold behavioural model.

module tb_seg_scan_decoder;
  localparam int STABLE_CYC  = 16;
  localparam int TIMEOUT_CYC = 100;
  localparam int CNT_W       = 21;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] an_r = 4'hF;
  logic [7:0] sgm_r = 8'hFF;
  logic [3:0] dig3, dig2, dig1, dig0, dp;
  logic       frame_done, err_code, err_anode, stale;

  seg_scan_decoder #(
    .STABLE_CYC  (STABLE_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .an         (an_r),
    .sgm        (sgm_r),
    .dig3       (dig3),
    .dig2       (dig2),
    .dig1       (dig1),
    .dig0       (dig0),
    .dp         (dp),
    .frame_done (frame_done),
    .err_code   (err_code),
    .err_anode  (err_anode),
    .stale      (stale)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int dut_frames = 0;

  always @(negedge clk) if (frame_done === 1'b1) dut_frames++;

  // Model state: shadow slots, pending mask, published frame, stickies.
  logic [3:0][3:0] m_shd, m_dig;
  logic [3:0]      m_sdp, m_dp, m_pend;
  bit              m_ec, m_ea;
  int              m_frames = 0;
  int              cyc = 0;
  int              last_acc = 0;

  logic [6:0] CODES [11] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                             7'h02, 7'h78, 7'h00, 7'h10, 7'h7F};

  function automatic logic [3:0] ref_dec(input logic [6:0] s, output bit bad);
    bad = 1'b0;
    for (int d = 0; d < 10; d++) if (CODES[d] == s) return 4'(d);
    if (s == 7'h7F) return 4'hF;
    bad = 1'b1;
    return 4'hF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dig0"}, dig0, m_dig[0]);
    chk({tag, ".dig1"}, dig1, m_dig[1]);
    chk({tag, ".dig2"}, dig2, m_dig[2]);
    chk({tag, ".dig3"}, dig3, m_dig[3]);
    chk({tag, ".dp"}, dp, m_dp);
    chk({tag, ".err_code"}, err_code, m_ec);
    chk({tag, ".err_anode"}, err_anode, m_ea);
    chk({tag, ".stale"}, stale, (cyc - last_acc) >= TIMEOUT_CYC);
    chk({tag, ".frames"}, dut_frames, m_frames);
  endtask

  task automatic model_reset();
    m_shd = {4{4'hF}}; m_dig = {4{4'hF}};
    m_sdp = '0; m_dp = '0; m_pend = '0;
    m_ec = 1'b0; m_ea = 1'b0;
    cyc = 0; last_acc = 0;
  endtask

  // Asserts reset (checking its immediate effect) and releases it just after an edge.
  task automatic do_reset();
    rst = 1'b1; an_r = 4'hF; sgm_r = 8'hFF;
    #1;
    chk("rst.dig0", dig0, 4'hF);
    chk("rst.dig1", dig1, 4'hF);
    chk("rst.dig2", dig2, 4'hF);
    chk("rst.dig3", dig3, 4'hF);
    chk("rst.dp", dp, 4'h0);
    chk("rst.frame_done", frame_done, 1'b0);
    chk("rst.err_code", err_code, 1'b0);
    chk("rst.err_anode", err_anode, 1'b0);
    chk("rst.stale", stale, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // Hold one bus value for L clock cycles, then advance the model. A hold of
  // STABLE_CYC+1 cycles is accepted, taking effect 2+STABLE_CYC+1 edges after the value was driven.
  task automatic seg(input logic [3:0] a, input logic [7:0] s, input int L, input bit lat = 1'b0);
    int st, idx;
    bit bad;
    logic [3:0] d;
    st = cyc;
    an_r = a; sgm_r = s;
    if (lat) begin
      repeat (STABLE_CYC + 2) @(posedge clk);
      #1 chk("latency_early", frame_done, 1'b0);
      @(posedge clk);
      #1 chk("latency_hit", frame_done, 1'b1);
      repeat (L - STABLE_CYC - 3) @(posedge clk);
      #1;
    end else begin
      repeat (L) @(posedge clk);
      #1;
    end
    cyc = st + L;
    if (L > STABLE_CYC && a != 4'hF) begin
      last_acc = st + STABLE_CYC + 3;
      if ($countones(~a) == 1) begin
        idx = 0;
        for (int k = 0; k < 4; k++) if (!a[k]) idx = k;
        d = ref_dec(s[6:0], bad);
        m_shd[idx] = d;
        m_sdp[idx] = ~s[7];
        m_pend[idx] = 1'b1;
        if (bad) m_ec = 1'b1;
        if (m_pend == 4'hF) begin
          m_dig = m_shd; m_dp = m_sdp; m_pend = '0; m_frames++;
        end
      end else begin
        m_ea = 1'b1;
      end
    end
    check_all("seg");
  endtask

  typedef struct {
    logic [3:0][3:0] an;
    logic [3:0][7:0] sg;
    bit              pre_short;
    logic [15:0]     exp_dig;   // {dig3,dig2,dig1,dig0}
    logic [3:0]      exp_dp;
  } scan_t;

  scan_t tbl [4];

  initial begin
    int f0, r, L;
    logic [3:0] a, d0, d1, d2, d3;
    logic [7:0] s;

    tbl[0].an = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    tbl[0].sg = {8'hB0, 8'hA4, 8'hF9, 8'hC0};
    tbl[0].pre_short = 1'b0; tbl[0].exp_dig = 16'h3210; tbl[0].exp_dp = 4'b0000;
    tbl[1].an = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    tbl[1].sg = {8'hFF, 8'hA4, 8'h79, 8'hC0};
    tbl[1].pre_short = 1'b0; tbl[1].exp_dig = 16'hF210; tbl[1].exp_dp = 4'b0010;
    tbl[2].an = {4'b1110, 4'b1101, 4'b1011, 4'b0111};
    tbl[2].sg = {8'h78, 8'h82, 8'h19, 8'h90};
    tbl[2].pre_short = 1'b0; tbl[2].exp_dig = 16'h9467; tbl[2].exp_dp = 4'b0101;
    tbl[3].an = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    tbl[3].sg = {8'h80, 8'hF8, 8'h82, 8'h92};
    tbl[3].pre_short = 1'b1; tbl[3].exp_dig = 16'h8765; tbl[3].exp_dp = 4'b0000;

    #2;
    do_reset();

    for (int t = 0; t < 4; t++) begin
      f0 = dut_frames;
      if (tbl[t].pre_short)
        for (int k = 0; k < 4; k++) seg(tbl[t].an[k], tbl[t].sg[k] ^ 8'h01, 10);
      for (int k = 0; k < 4; k++) seg(tbl[t].an[k], tbl[t].sg[k], 64);
      chk("tbl.digits", {dig3, dig2, dig1, dig0}, tbl[t].exp_dig);
      chk("tbl.dp", dp, tbl[t].exp_dp);
      chk("tbl.err_code", err_code, 1'b0);
      chk("tbl.err_anode", err_anode, 1'b0);
      chk("tbl.one_frame", dut_frames - f0, 1);
    end

    // Frame latency measured from the fourth slot's arrival at the pins.
    seg(4'b1110, 8'hC0, 64);
    seg(4'b1101, 8'hF9, 64);
    seg(4'b1011, 8'hA4, 64);
    seg(4'b0111, 8'hB0, 64, 1'b1);

    // Multi-low anode mid-scan: flags error, leaves pending alone.
    f0 = dut_frames;
    seg(4'b1110, 8'hF9, 64);
    seg(4'b1101, 8'hA4, 64);
    seg(4'b1100, 8'hC0, 64);
    chk("anode.err", err_anode, 1'b1);
    chk("anode.no_frame", dut_frames - f0, 0);
    seg(4'b1011, 8'hB0, 64);
    seg(4'b0111, 8'h99, 64);
    chk("anode.frame", dut_frames - f0, 1);
    chk("anode.digits", {dig3, dig2, dig1, dig0}, 16'h4321);

    // Undecodable pattern: blank digit, sticky code error.
    seg(4'b1110, 8'hD5, 64);
    seg(4'b1101, 8'hF9, 64);
    seg(4'b1011, 8'hA4, 64);
    seg(4'b0111, 8'hB0, 64);
    chk("code.err", err_code, 1'b1);
    chk("code.dig0", dig0, 4'hF);
    seg(4'b1110, 8'hC0, 64);
    seg(4'b1101, 8'hF9, 64);
    seg(4'b1011, 8'hA4, 64);
    seg(4'b0111, 8'hB0, 64);
    chk("code.sticky", err_code, 1'b1);

    // Timeout with a blank bus, then recovery on the next accept.
    d0 = dig0; d1 = dig1; d2 = dig2; d3 = dig3;
    seg(4'b1111, 8'hFF, 130);
    chk("stale.set", stale, 1'b1);
    chk("stale.digits_kept", {dig3, dig2, dig1, dig0}, {d3, d2, d1, d0});
    seg(4'b1110, 8'hC0, 30);
    chk("stale.clear", stale, 1'b0);

    // Reset mid-scan clears pending as well as outputs.
    seg(4'b1101, 8'hF9, 64);
    seg(4'b1011, 8'hA4, 64);
    an_r = 4'b0111; sgm_r = 8'h99;
    repeat (5) @(posedge clk);
    #3;
    do_reset();
    f0 = dut_frames;
    seg(4'b1011, 8'hA4, 64);
    seg(4'b0111, 8'hB0, 64);
    chk("rst.pending_cleared", dut_frames - f0, 0);
    seg(4'b1110, 8'hC0, 64);
    seg(4'b1101, 8'hF9, 64);
    chk("rst.frame_after", dut_frames - f0, 1);
    chk("rst.digits_after", {dig3, dig2, dig1, dig0}, 16'h3210);

    // Random holds, short ones well below and long ones well above the threshold.
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 12) a = 4'hF;
      else a = ~(4'b0001 << $urandom_range(0, 3));
      r = int'($urandom_range(0, 99));
      if (r < 10) s[6:0] = 7'($urandom);
      else s[6:0] = CODES[$urandom_range(0, 10)];
      s[7] = 1'($urandom_range(0, 1));
      if ({a, s} == {an_r, sgm_r}) s[7] = ~s[7];
      if ($urandom_range(0, 2) == 0) L = int'($urandom_range(2, 12));
      else L = int'($urandom_range(24, 40));
      seg(a, s, L);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed 7-segment display driver.
- Watches the active-low anode/segment bus (an, sgm), waits for each anode slot to settle, and decodes the segment pattern back to a BCD digit.
- After all four slots have been seen, it publishes the four digits together as one frame.
- Used as an in-system display monitor and as a self-checking bench component for the stopwatch datapath.

Parameters:
- STABLE_CYC, 16, consecutive clk cycles an/sgm must hold unchanged before a slot is accepted (min 2).
- TIMEOUT_CYC, 2000000, clk cycles with no accepted slot before stale asserts.
- CNT_W, 21, width of the internal stability/timeout counters; must hold TIMEOUT_CYC.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- an  in  4  anode enables, active-low; an[i]=0 selects digit i.
- sgm  in  8  segments, active-low; sgm[0]=a … sgm[6]=g, sgm[7]=dp.
- dig3  out  4  decoded digit for an[3]: 0–9, or 4'hF when blank.
- dig2  out  4  decoded digit for an[2], same encoding.
- dig1  out  4  decoded digit for an[1], same encoding.
- dig0  out  4  decoded digit for an[0], same encoding.
- dp  out  4  decimal-point state per digit, active-high (1 = lit).
- frame_done  out  1  one-cycle pulse when dig*/dp update.
- err_code  out  1  sticky: an accepted sgm[6:0] pattern was not in the decode table.
- err_anode  out  1  sticky: an accepted an had more than one bit low.
- stale  out  1  level: no slot accepted for TIMEOUT_CYC cycles.

Behaviour:
- Reset values: dig0–dig3 = 4'hF; dp, frame_done, err_code, err_anode, stale = 0. Reset also clears all internal state, including the pending-slot mask and counters. Reset can assert at any time, including mid-frame, and takes effect immediately.
- Input conditioning: an and sgm pass through a 2-flop synchronizer (12 bits). All later logic uses the synchronized copy.
- Stability check:
  - A pattern register holds the last synchronized {an,sgm}. The stability counter resets to 0 whenever the current value differs from it.
  - When the counter reaches STABLE_CYC-1 with an unchanged value, the slot is accepted once. The counter then saturates, so there is no re-accept until the input changes.
- Accept rules:
  - an = 4'b1111: ignored. No accept, no error, and the timeout counter keeps running.
  - an exactly one bit low (bit i): decode sgm[6:0], write the result to shadow slot i with dp_shadow[i] = ~sgm[7], and set pending[i].
  - an with two or more bits low: set err_anode. No shadow write and no pending change.
- Decode table (sgm[6:0], hex → digit):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 7F→F (blank).
  - Any other pattern writes F to the slot, sets pending[i], and sets err_code.
- Frame completion:
  - When pending becomes 4'b1111, in that same cycle copy the four shadow digits into dig3..dig0 and dp_shadow into dp, pulse frame_done for one cycle, and clear pending.
  - A slot accepted again before the frame completes overwrites its shadow value; the newest value wins.
  - Scan order does not matter.
- Latency: frame_done rises 2 (sync) + STABLE_CYC + 1 cycles after the fourth distinct slot's pattern arrives at the pins.
- Timeout: the timeout counter clears on every accept.
  - When it reaches TIMEOUT_CYC, stale is set to 1 and the counter saturates.
  - stale is cleared to 0 on the next accept.
  - Outputs keep their last frame while stale.
- Sticky errors clear only on rst.
- Glitches shorter than STABLE_CYC cycles (for example, ghosting at anode transitions) must never cause an accept.

Test Plan:
- Scan an=1110/1101/1011/0111 with sgm=40,79,24,30, holding each 64 cycles (STABLE_CYC=16) → one frame_done; dig0..dig3=0,1,2,3; dp=0000; no errors.
- Same scan, but digit 1 uses sgm=79 with sgm[7]=0, and digit 3 uses sgm=7F → dp=0010; dig3=F; err_code=0.
- Hold each slot for only 10 cycles, then a full 64-cycle scan of 12,02,78,00 → exactly one frame_done, with dig0..dig3=5,6,7,8. The short holds produce no accepts.
- Drive an=1100 for 64 cycles → err_anode=1, pending unchanged; a later valid full scan still yields frame_done.
- Drive sgm=7'h55 on an=1110, then complete the scan → err_code=1 and dig0=F at frame_done; err_code stays 1 until rst.
- Hold an=1111 for TIMEOUT_CYC (bench override 100) cycles → stale=1 with digits unchanged. Next valid accept → stale=0. Assert rst mid-scan → all outputs return to reset values and pending is cleared.
